// File: rtl/edge_pkg.sv
// Shared types and frame geometry for the edge-detector pipeline.
package edge_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LINE_W  = 38;
  localparam int unsigned FRAME_H = 30;
  localparam int unsigned DEPTH   = 2 * LINE_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/wrap_counter.sv
// Up-counter that wraps MAX -> 0; wrap flags the increment that rolls over.
module wrap_counter #(
  parameter int unsigned  MAX = 1,
  localparam int unsigned W   = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = inc && (count == W'(MAX));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Write sequencer for the two-line shift_76 buffer; tracks frame position and
// flags when a full 3x3 Sobel window is available.
module line_buffer_ctrl #(
  parameter int unsigned DATA_W  = edge_pkg::DATA_W,
  parameter int unsigned LINE_W  = edge_pkg::LINE_W,
  parameter int unsigned DEPTH   = edge_pkg::DEPTH,
  parameter int unsigned FRAME_H = edge_pkg::FRAME_H,
  parameter int unsigned ADDR_W  = 7,
  localparam int unsigned COL_W  = $clog2(LINE_W),
  localparam int unsigned ROW_W  = $clog2(FRAME_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              buf_ready,
  output logic              buf_write_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [DATA_W-1:0] buf_wr_data,
  input  logic              k_ready,
  output logic              win_valid,
  output logic [COL_W-1:0]  win_col,
  output logic [ROW_W-1:0]  win_row,
  output logic              frame_done
);

  import edge_pkg::*;

  state_t            state, state_nx;
  logic              accept, start, win_hit;
  logic              addr_wrap, col_wrap, row_wrap;
  logic [ADDR_W-1:0] addr;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;

  assign s_ready = ((state == PRIME) || (state == STREAM)) && buf_ready && k_ready;
  assign accept  = s_valid && s_ready;
  // A new frame may not arm while the previous frame_done pulse is still out.
  assign start   = (state == IDLE) && frame_start && !frame_done;
  assign win_hit = accept && (state == STREAM) && (col >= COL_W'(2));

  wrap_counter #(.MAX(DEPTH - 1)) u_addr (
    .clk(clk), .rst(rst), .clr(start), .inc(accept), .count(addr), .wrap(addr_wrap)
  );

  wrap_counter #(.MAX(LINE_W - 1)) u_col (
    .clk(clk), .rst(rst), .clr(start), .inc(accept), .count(col), .wrap(col_wrap)
  );

  wrap_counter #(.MAX(FRAME_H - 1)) u_row (
    .clk(clk), .rst(rst), .clr(start), .inc(col_wrap), .count(row), .wrap(row_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = PRIME;
      PRIME:   if (col_wrap && (row == ROW_W'(1))) state_nx = STREAM;
      STREAM:  if (row_wrap) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One-cycle-latency write and window outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_write_en <= 1'b0;
      buf_wr_addr  <= '0;
      buf_wr_data  <= '0;
      win_valid    <= 1'b0;
      win_col      <= '0;
      win_row      <= '0;
      frame_done   <= 1'b0;
    end else begin
      buf_write_en <= accept;
      win_valid    <= win_hit;
      frame_done   <= (state == DONE);
      if (accept) begin
        buf_wr_addr <= addr;
        buf_wr_data <= s_data;
      end
      if (win_hit) begin
        win_row <= row - ROW_W'(1);
        win_col <= col - COL_W'(1);
      end
    end
  end

  // DEPTH spans exactly two lines, so the address rolls over only at odd line ends.
  a_addr_lockstep: assert property (@(posedge clk) disable iff (rst)
    addr_wrap == (col_wrap && row[0]));

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl: table of start-up vectors, then
// full-frame streaming with stalls, mid-frame reset and restart.
module tb_line_buffer_ctrl;

  localparam int NPIX = 1140;
  localparam int LW   = 38;
  localparam int DP   = 76;

  logic        clk = 1'b0;
  logic        rst, frame_start, s_valid, s_ready, buf_ready, k_ready;
  logic [31:0] s_data, buf_wr_data;
  logic        buf_write_en, win_valid, frame_done;
  logic [6:0]  buf_wr_addr;
  logic [5:0]  win_col;
  logic [4:0]  win_row;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  line_buffer_ctrl dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .buf_ready(buf_ready), .buf_write_en(buf_write_en),
    .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .k_ready(k_ready), .win_valid(win_valid), .win_col(win_col),
    .win_row(win_row), .frame_done(frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Streams pixels first..last into an already-armed frame and checks every cycle.
  task automatic run_stream(input int first, input int last, input bit stall, input int exp_wins);
    int p = first, cyc = 0, done_cyc = -1, extra = 0;
    int n_wr = 0, n_win = 0, n_fd = 0, row, col;
    bit br, kr, exp_rdy, exp_acc, exp_win;
    while (extra < 3) begin
      if (cyc >= 4000) begin
        chk("stream_timeout", 32'(p), 32'(last + 1));
        break;
      end
      br = !(stall && cyc >= 100 && cyc <= 122);
      kr = !(stall && cyc >= 300 && cyc <= 304);
      buf_ready = br;
      k_ready   = kr;
      s_valid   = (p <= last) && ((cyc % 13) != 7);
      s_data    = 32'(p);
      frame_start = stall && (cyc == 400);
      #1;
      exp_rdy = (p < NPIX) && br && kr;
      chk("s_ready", 32'(s_ready), 32'(exp_rdy));
      exp_acc = s_valid && exp_rdy;
      row = p / LW;
      col = p % LW;
      exp_win = exp_acc && row >= 2 && col >= 2;
      @(posedge clk); #1;
      chk("write_en", 32'(buf_write_en), 32'(exp_acc));
      chk("win_valid", 32'(win_valid), 32'(exp_win));
      if (buf_write_en) n_wr++;
      if (win_valid) n_win++;
      if (frame_done) n_fd++;
      if (exp_acc) begin
        chk("wr_addr", 32'(buf_wr_addr), 32'(p % DP));
        chk("wr_data", buf_wr_data, 32'(p));
        if (exp_win) begin
          chk("win_row", 32'(win_row), 32'(row - 1));
          chk("win_col", 32'(win_col), 32'(col - 1));
        end
        p++;
        if (p == NPIX) done_cyc = cyc;
      end
      chk("frame_done", 32'(frame_done), 32'(done_cyc >= 0 && cyc == done_cyc + 1));
      if (p > last) extra++;
      cyc++;
    end
    frame_start = 1'b0;
    s_valid = 1'b0;
    chk("write_count", 32'(n_wr), 32'(last - first + 1));
    chk("win_count", 32'(n_win), 32'(exp_wins));
    chk("frame_done_count", 32'(n_fd), 32'(last == NPIX - 1));
  endtask

  typedef struct {
    logic        rst, fs, sv, br, kr;
    logic [31:0] data;
    logic        exp_rdy, exp_we;
    logic [6:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst   fs    sv    br    kr    data  rdy   we    addr  wdata
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 1'b0, 7'd0, 32'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 1'b0, 7'd0, 32'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 1'b0, 7'd0, 32'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0,  1'b1, 1'b1, 7'd0, 32'd0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd1,  1'b1, 1'b1, 7'd1, 32'd1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd99, 1'b1, 1'b0, 7'd0, 32'd0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd2,  1'b0, 1'b0, 7'd0, 32'd0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd2,  1'b0, 1'b0, 7'd0, 32'd0};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd2,  1'b1, 1'b1, 7'd2, 32'd2};
    vecs[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'd3,  1'b1, 1'b1, 7'd3, 32'd3};

    rst = 1'b1; frame_start = 1'b0; s_valid = 1'b0; s_data = '0;
    buf_ready = 1'b1; k_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      rst = vecs[i].rst; frame_start = vecs[i].fs; s_valid = vecs[i].sv;
      buf_ready = vecs[i].br; k_ready = vecs[i].kr; s_data = vecs[i].data;
      #1;
      chk($sformatf("vec%0d s_ready", i), 32'(s_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d write_en", i), 32'(buf_write_en), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d win_valid", i), 32'(win_valid), 32'd0);
      if (vecs[i].exp_we) begin
        chk($sformatf("vec%0d wr_addr", i), 32'(buf_wr_addr), 32'(vecs[i].exp_addr));
        chk($sformatf("vec%0d wr_data", i), buf_wr_data, vecs[i].exp_data);
      end
    end
    frame_start = 1'b0;

    // Rest of frame 1 with buf_ready/k_ready stalls and a stray frame_start.
    run_stream(4, NPIX - 1, 1'b1, 1008);

    // Frame 2: arm, stream 500 pixels, then reset mid-frame.
    frame_start = 1'b1; s_valid = 1'b0; #1;
    chk("arm2 s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    frame_start = 1'b0;
    run_stream(0, 499, 1'b0, 400);

    rst = 1'b1; s_valid = 1'b1; s_data = 32'd500;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst write_en", 32'(buf_write_en), 32'd0);
    chk("rst wr_addr", 32'(buf_wr_addr), 32'd0);
    chk("rst wr_data", buf_wr_data, 32'd0);
    chk("rst win_valid", 32'(win_valid), 32'd0);
    chk("rst win_row", 32'(win_row), 32'd0);
    chk("rst win_col", 32'(win_col), 32'd0);
    chk("rst frame_done", 32'(frame_done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_rst s_ready", 32'(s_ready), 32'd0);
      @(posedge clk); #1;
      chk("post_rst write_en", 32'(buf_write_en), 32'd0);
    end

    // Frame 3: frame_start together with s_valid must not accept that cycle.
    frame_start = 1'b1; s_valid = 1'b1; s_data = 32'd0; #1;
    chk("arm3 s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    chk("arm3 write_en", 32'(buf_write_en), 32'd0);
    frame_start = 1'b0;
    run_stream(0, NPIX - 1, 1'b0, 1008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Sequencer for the 76-deep, 32-bit `shift_76` line buffer in the edge-detector pipeline. It accepts a raw pixel stream with a valid/ready handshake and generates the buffer's `write_en`, wrapping `wr_addr` and `wr_data`. It tracks column and row position within the frame. It flags when a complete 3x3 window is available to the Sobel kernel, so address generation no longer sits outside the buffer.

## Interface
Parameters:
- DATA_W, 32, pixel word width
- LINE_W, 38, pixels per image line
- DEPTH, 76, buffer depth; equals 2*LINE_W
- FRAME_H, 30, lines per frame
- ADDR_W, 7, buffer address width; ceil(log2(DEPTH))

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  single-cycle pulse; arms a new frame
- s_valid  in  1  upstream pixel valid
- s_data  in  DATA_W  upstream pixel
- s_ready  out  1  controller can accept a pixel
- buf_ready  in  1  `ready` from shift_76
- buf_write_en  out  1  to shift_76 `write_en`
- buf_wr_addr  out  ADDR_W  to shift_76 `wr_addr`
- buf_wr_data  out  DATA_W  to shift_76 `wr_data`
- k_ready  in  1  downstream kernel can take a window
- win_valid  out  1  3x3 window centred at (win_row, win_col) is complete
- win_col  out  6  centre column, 1..LINE_W-2
- win_row  out  5  centre row, 1..FRAME_H-2
- frame_done  out  1  single-cycle pulse after the last pixel of a frame is written

## Operation
- FSM states: IDLE, PRIME, STREAM, DONE. Reset state is IDLE.
- IDLE:
  - s_ready is 0.
  - frame_start moves the FSM to PRIME and clears col, row and address to 0.
- PRIME:
  - The first 2*LINE_W pixels, rows 0 and 1, are accepted.
  - win_valid stays 0.
  - After the accept of pixel (row 1, col LINE_W-1), the FSM moves to STREAM.
- STREAM:
  - Rows 2..FRAME_H-1 are accepted.
  - An accepted pixel at (r, c) with c ≥ 2 produces win_valid with win_row = r-1 and win_col = c-1.
  - After the accept of pixel (FRAME_H-1, LINE_W-1), the FSM moves to DONE.
- DONE:
  - frame_done is 1 for exactly one cycle, then the FSM returns to IDLE.
- Handshake:
  - s_ready = (PRIME or STREAM) && buf_ready && k_ready.
  - accept = s_valid && s_ready.
  - No pixel is accepted in IDLE or DONE.
- Counters advance only on accept:
  - Address wraps DEPTH-1 → 0.
  - col wraps LINE_W-1 → 0 and increments row at the wrap.
  - Address is not reset at line boundaries, only on frame_start.
- frame_start outside IDLE is ignored.
- frame_start and s_valid in the same IDLE cycle: the pixel is not accepted that cycle.
- Deasserting buf_ready or k_ready mid-line stalls acceptance. Counters hold and no write is issued.

## Timing
- Latency is one cycle. An accept at edge T produces, on cycle T+1:
  - buf_write_en=1
  - buf_wr_addr = pre-increment address
  - buf_wr_data = s_data
  - win_valid/win_row/win_col for that pixel (when applicable)
- All outputs are registered. s_ready is combinational from state and the ready inputs.
- win_valid and buf_write_en are 1-cycle pulses per accepted pixel and are never asserted without a matching write.
- frame_done asserts the cycle after the last pixel's write pulse.
- Reset values: all outputs 0, FSM IDLE, all counters 0.
- Reset mid-frame discards the partial frame. The next frame needs a new frame_start.
- Back-to-back frames: frame_start is accepted at earliest on the cycle after frame_done, giving a minimum 2-cycle gap between frames.

## Structure
- Shared package `edge_pkg`:
  - LINE_W, FRAME_H, DEPTH, DATA_W
  - state enum {IDLE, PRIME, STREAM, DONE}
- One sub-module, `wrap_counter` (parameter MAX; ports clk, rst, clr, inc, count, wrap). It is instantiated three times: address (MAX=DEPTH-1), column (MAX=LINE_W-1), row (MAX=FRAME_H-1).
- The controller instantiates no buffer. shift_76 is wired beside it at the next level up.

## Test plan
- Reset, then frame_start, then continuous pixels with data = index 0..1139. Required response:
  - 1140 write pulses
  - buf_wr_addr sequence 0..75,0..75,…
  - first win_valid with pixel 78 (row 2, col 2), win_row=1, win_col=1
  - 36*28 = 1008 win_valid pulses total
  - frame_done one cycle after the write of pixel 1139
- Address wrap: pixel 75 is written to addr 75 and pixel 76 to addr 0, with buf_wr_data 75 and 76 respectively.
- Stall: buf_ready=0 for cycles 100–122. Required response: s_ready=0, no write_en, and counters held; the stream resumes at the same address with no lost or duplicated pixel.
- k_ready=0 for 5 cycles during STREAM gives the same hold behaviour. A frame_start pulsed mid-frame changes nothing.
- rst asserted at pixel 500. Required response: next cycle all outputs 0, FSM IDLE, and s_ready=0 until a new frame_start. The new frame starts at addr 0, row 0, col 0.
- frame_start with s_valid=1 in the same cycle: no accept that cycle, and the first write occurs one cycle later with addr 0.
